// File: rtl/led_driver_ctrl.sv
// led_driver_ctrl: transmit-side controller for an STP16-style LED shift-register driver.
// It serialises a C_N-bit word MSB first onto LED_SDI/LED_Clk and pulses LED_LE to latch it.
// The driver's LED_SDO is captured during the same frame, so Rd_data returns the previous contents.
// A free-running PWM counter drives active-low LED_OE independently of the frame FSM.
module led_driver_ctrl #(
    parameter int C_N       = 16,
    parameter int C_CLK_DIV = 4,
    parameter int C_LE_CYC  = 2,
    parameter int C_PWM_W   = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [C_N-1:0]     Data_in,
    output logic               Busy,
    output logic               Done,
    output logic [C_N-1:0]     Rd_data,
    input  logic [C_PWM_W-1:0] Bright,
    input  logic               Blank,
    output logic               LED_Clk,
    output logic               LED_SDI,
    output logic               LED_LE,
    output logic               LED_OE,
    input  logic               LED_SDO
);

    // One phase counter serves both the shift half-periods and the latch pulse.
    localparam int PH_MAX = (C_CLK_DIV > C_LE_CYC) ? C_CLK_DIV : C_LE_CYC;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int BIT_W  = $clog2(C_N);

    localparam logic [PH_W-1:0]  DIV_LAST = PH_W'(C_CLK_DIV - 1);
    localparam logic [PH_W-1:0]  LE_LAST  = PH_W'(C_LE_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(C_N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    state_t             state, state_next;
    logic [PH_W-1:0]    ph_cnt, ph_cnt_next;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_next;
    logic [C_N-1:0]     tx, tx_next;
    logic [C_N-1:0]     rx, rx_next;
    logic [C_N-1:0]     rd_next;
    logic               done_next;

    logic [C_PWM_W-1:0] pwm_cnt;
    logic [C_PWM_W-1:0] bright_lat;

    // Next-state and datapath updates for the frame sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_next   = state;
        ph_cnt_next  = ph_cnt;
        bit_cnt_next = bit_cnt;
        tx_next      = tx;
        rx_next      = rx;
        rd_next      = Rd_data;
        done_next    = 1'b0;

        case (state)
            IDLE: begin
                // The Done cycle is still IDLE, but a request there is dropped, not queued.
                if (Start && !Done) begin
                    tx_next      = Data_in;
                    bit_cnt_next = BIT_TOP;
                    ph_cnt_next  = '0;
                    state_next   = SHIFT_LO;
                end
            end

            SHIFT_LO: begin
                if (ph_cnt == DIV_LAST) begin
                    // SDO is sampled on the same edge that raises LED_Clk, i.e. before the driver shifts.
                    ph_cnt_next = '0;
                    rx_next     = {rx[C_N-2:0], LED_SDO};
                    state_next  = SHIFT_HI;
                end else begin
                    ph_cnt_next = ph_cnt + 1'b1;
                end
            end

            SHIFT_HI: begin
                if (ph_cnt == DIV_LAST) begin
                    ph_cnt_next = '0;
                    if (bit_cnt == '0) begin
                        state_next = LATCH;
                    end else begin
                        bit_cnt_next = bit_cnt - 1'b1;
                        tx_next      = {tx[C_N-2:0], 1'b0};
                        state_next   = SHIFT_LO;
                    end
                end else begin
                    ph_cnt_next = ph_cnt + 1'b1;
                end
            end

            LATCH: begin
                if (ph_cnt == LE_LAST) begin
                    ph_cnt_next = '0;
                    done_next   = 1'b1;
                    rd_next     = rx;
                    state_next  = IDLE;
                end else begin
                    ph_cnt_next = ph_cnt + 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // State register; pin outputs are registered from the next state so they align with it.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (Rst) begin
            state   <= IDLE;
            ph_cnt  <= '0;
            bit_cnt <= '0;
            tx      <= '0;
            rx      <= '0;
            Rd_data <= '0;
            Done    <= 1'b0;
            Busy    <= 1'b0;
            LED_Clk <= 1'b0;
            LED_SDI <= 1'b0;
            LED_LE  <= 1'b0;
        end else begin
            state   <= state_next;
            ph_cnt  <= ph_cnt_next;
            bit_cnt <= bit_cnt_next;
            tx      <= tx_next;
            rx      <= rx_next;
            Rd_data <= rd_next;
            Done    <= done_next;
            Busy    <= (state_next != IDLE);
            LED_Clk <= (state_next == SHIFT_HI);
            LED_LE  <= (state_next == LATCH);
            LED_SDI <= ((state_next == SHIFT_LO) || (state_next == SHIFT_HI)) ? tx_next[C_N-1] : 1'b0;
        end
    end

    // PWM dimming: brightness is only taken at the period boundary so a duty change never glitches.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pwm_cnt    <= '0;
            bright_lat <= '0;
            LED_OE     <= 1'b1;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == '1) begin
                bright_lat <= Bright;
            end
            LED_OE <= Blank | ~(pwm_cnt < bright_lat);
        end
    end

endmodule

// File: tb/tb_led_driver_ctrl.sv
// tb_led_driver_ctrl: directed bench for led_driver_ctrl with a behavioural STP16 driver attached.
// Inputs change after the falling edge; outputs are sampled on the falling edge.
module tb_led_driver_ctrl;

    localparam int N = 16;
    localparam int W = 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Start;
    logic [N-1:0]  Data_in;
    logic          Busy;
    logic          Done;
    logic [N-1:0]  Rd_data;
    logic [W-1:0]  Bright;
    logic          Blank;
    logic          LED_Clk;
    logic          LED_SDI;
    logic          LED_LE;
    logic          LED_OE;
    logic          LED_SDO;

    int total = 0;
    int bad   = 0;

    // Event counters observed by the directed sequence through snapshots.
    int rise_cnt = 0;
    int le_cnt   = 0;
    int done_cnt = 0;

    // Behavioural driver: shift register, output latch, SDO from the last stage.
    logic [N-1:0] drv_sr = 16'h0000;
    logic [N-1:0] drv_po = 16'h0000;

    led_driver_ctrl #(
        .C_N      (N),
        .C_CLK_DIV(2),
        .C_LE_CYC (2),
        .C_PWM_W  (W)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Start  (Start),
        .Data_in(Data_in),
        .Busy   (Busy),
        .Done   (Done),
        .Rd_data(Rd_data),
        .Bright (Bright),
        .Blank  (Blank),
        .LED_Clk(LED_Clk),
        .LED_SDI(LED_SDI),
        .LED_LE (LED_LE),
        .LED_OE (LED_OE),
        .LED_SDO(LED_SDO)
    );

    // System clock, 10 ns period.
    always #5 Clk = ~Clk;

    // Driver shifts on the rising shift clock.
    always @(posedge LED_Clk) begin
        drv_sr   <= {drv_sr[N-2:0], LED_SDI};
        rise_cnt <= rise_cnt + 1;
    end

    // Driver latches its shift register on the latch pulse.
    always @(posedge LED_LE) begin
        drv_po <= drv_sr;
    end

    assign LED_SDO = drv_sr[N-1];

    // Count latch-high and Done cycles as seen at the sampling edge.
    always @(negedge Clk) begin
        if (LED_LE === 1'b1) le_cnt <= le_cnt + 1;
        if (Done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where Done is seen.
    // lat counts clocks from the accepting edge to the Done cycle.
    task automatic run_frame(input logic [N-1:0] word, output int lat);
        Start   = 1'b1;
        Data_in = word;
        @(negedge Clk);
        Start = 1'b0;
        lat   = 1;
        while (Done !== 1'b1 && lat < 400) begin
            @(negedge Clk);
            lat++;
        end
    endtask

    // Wait for the single OE-high sample that follows the last count of a PWM period.
    task automatic wait_oe_high(input string tag);
        int n;
        n = 0;
        @(negedge Clk);
        while (LED_OE !== 1'b1 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        check(tag, 32'(LED_OE), 32'd1);
    endtask

    initial begin
        int lat;
        int r0;
        int l0;
        int d0;
        int lows;
        int lows2;
        int highs;
        int n;

        Rst     = 1'b1;
        Start   = 1'b0;
        Data_in = '0;
        Bright  = '0;
        Blank   = 1'b0;
        repeat (3) @(negedge Clk);

        // Reset values.
        check("rst_led_clk", 32'(LED_Clk), 32'd0);
        check("rst_sdi",     32'(LED_SDI), 32'd0);
        check("rst_le",      32'(LED_LE),  32'd0);
        check("rst_oe",      32'(LED_OE),  32'd1);
        check("rst_busy",    32'(Busy),    32'd0);
        check("rst_done",    32'(Done),    32'd0);
        check("rst_rd_data", 32'(Rd_data), 32'd0);
        Rst = 1'b0;
        @(negedge Clk);

        // 1. Single frame into an all-zero driver.
        r0 = rise_cnt;
        l0 = le_cnt;
        run_frame(16'hA5C3, lat);
        check("f1_latency", 32'(lat),           32'd67);
        check("f1_rises",   32'(rise_cnt - r0), 32'd16);
        check("f1_le_cyc",  32'(le_cnt - l0),   32'd2);
        check("f1_busy",    32'(Busy),          32'd0);
        check("f1_rd_data", 32'(Rd_data),       32'h0000);
        check("f1_po",      32'(drv_po),        32'hA5C3);

        // 2. Start in the Done cycle is dropped; Start in the next cycle is taken.
        Start   = 1'b1;
        Data_in = 16'hFFFF;
        @(negedge Clk);
        check("f2_done_cycle_ignored", 32'(Busy), 32'd0);
        run_frame(16'h1234, lat);
        check("f2_latency", 32'(lat),     32'd67);
        check("f2_rd_data", 32'(Rd_data), 32'hA5C3);
        check("f2_po",      32'(drv_po),  32'h1234);

        // 3. Start while busy is ignored.
        @(negedge Clk);
        d0      = done_cnt;
        Start   = 1'b1;
        Data_in = 16'h5A0F;
        @(negedge Clk);
        Start = 1'b0;
        repeat (20) @(negedge Clk);
        check("f3_busy_mid", 32'(Busy), 32'd1);
        Start   = 1'b1;
        Data_in = 16'hFFFF;
        @(negedge Clk);
        Start   = 1'b0;
        Data_in = '0;
        repeat (120) @(negedge Clk);
        check("f3_one_done", 32'(done_cnt - d0), 32'd1);
        check("f3_po",       32'(drv_po),        32'h5A0F);
        check("f3_rd_data",  32'(Rd_data),       32'h1234);

        // 4. PWM duty for Bright = 0, 5, 15.
        highs = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge Clk);
            if (LED_OE === 1'b1) highs++;
        end
        check("pwm_b0_highs", 32'(highs), 32'd32);

        Bright = 4'd5;
        repeat (40) @(negedge Clk);
        lows = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            if (LED_OE === 1'b0) lows++;
        end
        check("pwm_b5_lows", 32'(lows), 32'd5);

        Bright = 4'd15;
        repeat (40) @(negedge Clk);
        lows = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            if (LED_OE === 1'b0) lows++;
        end
        check("pwm_b15_lows", 32'(lows), 32'd15);

        // Mid-period change: old duty finishes the period, new duty starts at the next one.
        wait_oe_high("pwm_sync_a");
        lows  = 0;
        lows2 = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge Clk);
            if (LED_OE === 1'b0) begin
                if (k <= 16) lows++;
                else lows2++;
            end
            if (k == 3) Bright = 4'd5;
        end
        check("pwm_mid_old_period", 32'(lows),  32'd15);
        check("pwm_mid_new_period", 32'(lows2), 32'd5);

        // 5. Blank overrides PWM from the next clock; PWM resumes in phase.
        Bright = 4'd15;
        repeat (40) @(negedge Clk);
        wait_oe_high("pwm_sync_b");
        Blank = 1'b1;
        highs = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (k == 1) check("blank_next_clock", 32'(LED_OE), 32'd1);
            if (LED_OE === 1'b1) highs++;
        end
        check("blank_held", 32'(highs), 32'd20);
        Blank = 1'b0;
        lows  = 0;
        for (int k = 21; k <= 31; k++) begin
            @(negedge Clk);
            if (LED_OE === 1'b0) lows++;
        end
        check("blank_resume_lows", 32'(lows), 32'd11);
        @(negedge Clk);
        check("blank_resume_phase", 32'(LED_OE), 32'd1);

        // 6. Reset in the middle of a frame, then a clean frame.
        r0      = rise_cnt;
        Start   = 1'b1;
        Data_in = 16'h3C00;
        @(negedge Clk);
        Start = 1'b0;
        n     = 0;
        while ((rise_cnt - r0) < 8 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check("rst_mid_rises", 32'(rise_cnt - r0), 32'd8);
        check("rst_mid_clk_hi", 32'(LED_Clk), 32'd1);
        Rst = 1'b1;
        @(negedge Clk);
        check("rst_mid_led_clk", 32'(LED_Clk), 32'd0);
        check("rst_mid_le",      32'(LED_LE),  32'd0);
        check("rst_mid_oe",      32'(LED_OE),  32'd1);
        check("rst_mid_busy",    32'(Busy),    32'd0);
        check("rst_mid_rd_data", 32'(Rd_data), 32'd0);
        Rst = 1'b0;
        d0  = done_cnt;
        repeat (30) @(negedge Clk);
        check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_mid_po_kept", 32'(drv_po),        32'h5A0F);
        check("rst_mid_partial", 32'(drv_sr),        32'h0F3C);
        run_frame(16'hC3A5, lat);
        check("f6_latency", 32'(lat),     32'd67);
        check("f6_rd_data", 32'(Rd_data), 32'h0F3C);
        check("f6_po",      32'(drv_po),  32'hC3A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
